// File: rtl/prio_burst_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// prio_burst_arbiter_pkg : shared types and helpers for the burst arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package prio_burst_arbiter_pkg;

   // Helpers operate on a fixed maximum width; callers size-cast in and out.
   localparam int unsigned MAX_PORTS = 32;
   localparam int unsigned MAX_IDX_W = 5;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   // Two's-complement trick isolates the lowest set bit.
   function automatic logic [MAX_PORTS-1:0] first_onehot(input logic [MAX_PORTS-1:0] vec);
      return vec & (~vec + MAX_PORTS'(1));
   endfunction

   function automatic logic [MAX_IDX_W-1:0] onehot_to_index(input logic [MAX_PORTS-1:0] vec);
      logic [MAX_IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_PORTS; i++) begin
         if (vec[i]) begin
            idx = idx | MAX_IDX_W'(i);
         end
      end
      return idx;
   endfunction

endpackage

`default_nettype wire

// File: rtl/prio_out_reg.sv
// ----------------------------------------------------------------------------
// prio_out_reg : valid/ready output register holding data, last and port
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module prio_out_reg #(
   parameter int DATA_WIDTH = 8,
   parameter int IDX_W      = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  last_i,
   input  logic [IDX_W-1:0]      port_i,
   input  logic                  ready_i,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  last_o,
   output logic [IDX_W-1:0]      port_o
);

   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] data_q,  data_d;
   logic                  last_q,  last_d;
   logic [IDX_W-1:0]      port_q,  port_d;

   // Payload fields only change on a load; they hold after the beat drains.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      last_d  = last_q;
      port_d  = port_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
         last_d  = last_i;
         port_d  = port_i;
      end else if (ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
         port_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
         port_q  <= port_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign last_o  = last_q;
   assign port_o  = port_q;

endmodule

`default_nettype wire

// File: rtl/prio_burst_arbiter.sv
// ----------------------------------------------------------------------------
// prio_burst_arbiter : fixed-priority, burst-locked valid/ready arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module prio_burst_arbiter
   import prio_burst_arbiter_pkg::*;
#(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_PORTS-1:0]            in_valid,
   input  logic [NUM_PORTS-1:0]            in_last,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
   output logic [NUM_PORTS-1:0]            in_ready,
   output logic                            out_valid,
   output logic [DATA_WIDTH-1:0]           out_data,
   output logic                            out_last,
   output logic [$clog2(NUM_PORTS)-1:0]    out_port,
   input  logic                            out_ready,
   output logic [NUM_PORTS-1:0]            grant,
   output logic                            busy
);

   localparam int IDX_W = $clog2(NUM_PORTS);

   arb_state_t              state_q;
   logic [NUM_PORTS-1:0]    grant_q;
   logic                    busy_q;

   logic [NUM_PORTS-1:0]    w_first;
   logic [IDX_W-1:0]        w_gidx;
   logic                    w_out_free;
   logic                    w_xfer;
   logic                    w_xfer_last;
   logic [DATA_WIDTH-1:0]   w_data;
   logic                    w_last;

   assign w_first = NUM_PORTS'(first_onehot(MAX_PORTS'(in_valid)));
   assign w_gidx  = IDX_W'(onehot_to_index(MAX_PORTS'(grant_q)));

   // grant_q is zero outside LOCKED, so this also gates ready while idle.
   assign w_out_free = !out_valid || out_ready;
   assign in_ready   = grant_q & {NUM_PORTS{w_out_free}};

   always_comb begin
      w_data = '0;
      w_last = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (grant_q[i]) begin
            w_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            w_last = in_last[i];
         end
      end
   end

   assign w_xfer      = |(in_valid & in_ready);
   assign w_xfer_last = w_xfer && w_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (|in_valid) begin
                  state_q <= LOCKED;
                  grant_q <= w_first;
                  busy_q  <= 1'b1;
               end
            end
            LOCKED: begin
               if (w_xfer_last) begin
                  state_q <= IDLE;
                  grant_q <= '0;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               grant_q <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   prio_out_reg #(
      .DATA_WIDTH (DATA_WIDTH),
      .IDX_W      (IDX_W)
   ) u_out_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (w_xfer),
      .data_i  (w_data),
      .last_i  (w_last),
      .port_i  (w_gidx),
      .ready_i (out_ready),
      .valid_o (out_valid),
      .data_o  (out_data),
      .last_o  (out_last),
      .port_o  (out_port)
   );

   assign grant = grant_q;
   assign busy  = busy_q;

endmodule

`default_nettype wire

// File: doc/prio_burst_arbiter.md
# prio_burst_arbiter

Sequential counterpart to the fixed-priority select-first multiplexer. The multiplexer consumes a set of select lines and forwards the first asserted input. This block produces those selects: it arbitrates among `NUM_PORTS` valid/ready requesters with fixed lowest-index-first priority and locks the grant for a whole burst. It forwards the granted stream through one registered output stage and drives a one-hot grant vector for downstream select logic. It sits in front of any shared sink, such as a bus master port or a shared FIFO.

## Interface
Parameters:
- `NUM_PORTS`, default 4: number of requesters, at least 2.
- `DATA_WIDTH`, default 8: payload width.

Ports:
- `clk`, input, 1: sole clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, `NUM_PORTS`: per-port valid.
- `in_last`, input, `NUM_PORTS`: per-port end-of-burst marker, qualified by valid.
- `in_data`, input, `NUM_PORTS*DATA_WIDTH`: flattened payloads; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `in_ready`, output, `NUM_PORTS`: per-port ready; at most one bit is set.
- `out_valid`, output, 1: output beat valid.
- `out_data`, output, `DATA_WIDTH`: output payload.
- `out_last`, output, 1: last beat of a burst.
- `out_port`, output, `$clog2(NUM_PORTS)`: index of the source of the current output beat.
- `out_ready`, input, 1: sink ready.
- `grant`, output, `NUM_PORTS`: registered one-hot grant; all zero when not locked.
- `busy`, output, 1: 1 while in LOCKED.

## Operation
- Two states: IDLE and LOCKED.
- **IDLE:**
  - If any `in_valid` bit is set, latch `grant` as the one-hot of the lowest set index and go to LOCKED.
  - Otherwise stay in IDLE with `grant` = 0.
- **LOCKED:**
  - `in_ready[g] = !out_valid || out_ready`, where g is the granted index. All other `in_ready` bits are 0.
  - A beat transfers when `in_valid[g] && in_ready[g]`.
  - On transfer, the output register loads the port-g data and last bit, and `out_port` = g.
  - A transfer with `in_last[g]` = 1 returns the block to IDLE and clears `grant` on the same edge.
- **Output register:**
  - `out_valid` sets on a transfer.
  - `out_valid` clears when `out_ready` is high and no new transfer occurs in that cycle.
  - Back-to-back beats sustain 1 beat/cycle when `out_ready` is held high.
- **Lock rules:**
  - The lock holds until `in_last` transfers, even if `in_valid[g]` drops mid-burst. There is no timeout.
  - Higher-priority requests arriving mid-burst are ignored until IDLE.
- **Fairness:** fixed priority; starvation of high indices is accepted by design.
- **Pipeline overlap:** arbitration in IDLE may proceed while the output register still holds an unaccepted final beat.

## Timing
- **Reset values:** `in_ready`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `out_port`=0, `grant`=0, `busy`=0, state IDLE.
- **Reset mid-burst:** immediate return to all reset values. The partial burst is dropped; no `out_last` is emitted.
- **Latency:**
  - Request first seen in IDLE at cycle 0.
  - `grant` and `busy` are high at cycle 1, along with `in_ready[g]` if the output register is free.
  - `out_valid` is high at cycle 2.
- **Burst turnaround:** minimum 1 idle cycle between bursts, i.e. the re-arbitration cycle.
- **Single-beat burst** (`in_last` on the first beat): LOCKED for exactly 1 cycle when `out_ready`=1.
- **Backpressure:** while `out_valid && !out_ready`, all `in_ready` bits are 0 and the output register holds its contents.

## Structure
- Package `prio_burst_arbiter_pkg`:
  - State enum `arb_state_t` {IDLE, LOCKED}.
  - Function `first_onehot(vec)`, which returns the one-hot of the lowest set bit.
  - Function `onehot_to_index(vec)`.
- One natural sub-module: `prio_out_reg`, the valid/ready output register holding data, last and port.
- The top level holds only the FSM and the grant logic.

## Test plan
- **Single requester:** `in_valid`=4'b0100, 3-beat burst 0x11/0x22/0x33 with last on 0x33, `out_ready`=1.
  - `grant`=4'b0100 at cycle 1.
  - `out_data` 0x11, 0x22, 0x33 on cycles 2–4, with `out_port`=2.
  - `out_last` set only on 0x33.
  - `busy` low at cycle 4.
- **Simultaneous requests:** `in_valid`=4'b1010, each port sending a 1-beat burst.
  - Port 1 is served first.
  - IDLE for 1 cycle, then port 3 is granted; `out_port` sequence is 1, 3.
- **Mid-burst preemption attempt:** port 2 locked; port 0 asserts valid in the middle.
  - `in_ready[0]` stays 0 until port 2's last beat transfers.
  - Port 0 is then granted on the next cycle.
- **Backpressure:** `out_ready`=0 for 3 cycles during a burst.
  - `out_data` is held and `in_ready`=0.
  - On release, throughput resumes at 1 beat/cycle and no beat is lost or duplicated.
- **Reset mid-burst:** `rst_n` pulsed low during beat 2 of 4.
  - All outputs return to zero asynchronously.
  - After release, a new request is granted from IDLE with standard 2-cycle latency.
